mem_stage: RTL

Memory-access stage of the MIPS pipeline, placed between the EX/MEM latch and the writeback stage. It performs byte, halfword and word loads and stores against an internal word-organised data memory. Load data is sign- or zero-extended. All results and control bits go into the MEM/WB register, which feeds the writeback mux directly. After reset, an init state machine zero-fills the memory. A registered debug read port gives the debug unit a view of memory contents.

---
 rtl/mem_stage.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MIPS memory-access stage: byte/half/word loads and stores against an internal
// word-organised data memory, MEM/WB output register, zero-fill on reset, debug read port.
module mem_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH      = 256,
    parameter int ADDR_BITS      = 8,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [DATA_WIDTH-1:0]     i_alu_result,
    input  logic [DATA_WIDTH-1:0]     i_write_data,
    input  logic                      i_memread,
    input  logic                      i_memwrite,
    input  logic [1:0]                i_size,
    input  logic                      i_unsigned,
    input  logic                      i_memtoreg,
    input  logic                      i_regwrite,
    input  logic                      i_return,
    input  logic                      i_halt,
    input  logic [REG_ADDR_WIDTH-1:0] i_regdest,
    input  logic [DATA_WIDTH-1:0]     i_return_address,
    input  logic [ADDR_BITS-1:0]      i_debug_addr,
    output logic                      o_ready,
    output logic [DATA_WIDTH-1:0]     o_dataread,
    output logic [DATA_WIDTH-1:0]     o_address,
    output logic                      o_memtoreg,
    output logic                      o_regwrite,
    output logic                      o_return,
    output logic                      o_halt,
    output logic [REG_ADDR_WIDTH-1:0] o_regdest,
    output logic [DATA_WIDTH-1:0]     o_return_address,
    output logic                      o_misaligned,
    output logic [DATA_WIDTH-1:0]     o_debug_data
);

    localparam int NBYTES = DATA_WIDTH / 8;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            lane,
        input logic [1:0]            size,
        input logic                  uns
    );
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        byte_s = word[8*lane +: 8];
        half_s = word[16*lane[1] +: 16];
        case (size)
            2'b00:   load_extend = {{(DATA_WIDTH-8){byte_s[7] & ~uns}}, byte_s};
            2'b01:   load_extend = {{(DATA_WIDTH-16){half_s[15] & ~uns}}, half_s};
            default: load_extend = word;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                      state_q, state_d;
    logic [ADDR_BITS-1:0]        clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0]       dataread_q, dataread_d;
    logic [DATA_WIDTH-1:0]       address_q, address_d;
    logic                        memtoreg_q, memtoreg_d;
    logic                        regwrite_q, regwrite_d;
    logic                        return_q, return_d;
    logic                        halt_q, halt_d;
    logic [REG_ADDR_WIDTH-1:0]   regdest_q, regdest_d;
    logic [DATA_WIDTH-1:0]       retaddr_q, retaddr_d;
    logic                        misaligned_q, misaligned_d;
    logic [DATA_WIDTH-1:0]       debug_q;

    logic [ADDR_BITS-1:0]        word_idx;
    logic [1:0]                  lane;
    logic                        misaligned;
    logic [NBYTES-1:0]           st_be;
    logic [DATA_WIDTH-1:0]       st_data;
    logic [NBYTES-1:0]           mem_be;
    logic [ADDR_BITS-1:0]        mem_widx;
    logic [DATA_WIDTH-1:0]       mem_wdata;
    logic                        unused_addr_hi;

    assign word_idx       = i_alu_result[ADDR_BITS+1:2];
    assign lane           = i_alu_result[1:0];
    assign unused_addr_hi = ^i_alu_result[DATA_WIDTH-1:ADDR_BITS+2];

    // Only real accesses can be misaligned; size 10 behaves as word
    always_comb begin
        misaligned = 1'b0;
        if (i_memread || i_memwrite) begin
            if (i_size == 2'b01)
                misaligned = lane[0];
            else if (i_size[1])
                misaligned = (lane != 2'b00);
        end
    end

    always_comb begin
        st_be   = '0;
        st_data = i_write_data;
        case (i_size)
            2'b00: begin
                st_be       = NBYTES'(1) << lane;
                st_data     = {NBYTES{i_write_data[7:0]}};
            end
            2'b01: begin
                st_be       = lane[1] ? 4'b1100 : 4'b0011;
                st_data     = {(NBYTES/2){i_write_data[15:0]}};
            end
            default: st_be = '1;
        endcase
    end

    // Memory write port: zero-fill during CLEAR, stores in RUN; nothing on a reset edge
    always_comb begin
        mem_be    = '0;
        mem_widx  = word_idx;
        mem_wdata = st_data;
        if (!i_reset) begin
            if (state_q == ST_CLEAR) begin
                mem_be    = '1;
                mem_widx  = clr_cnt_q;
                mem_wdata = '0;
            end else if (i_enable && i_memwrite && !misaligned) begin
                mem_be = st_be;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < NBYTES; b++)
            if (mem_be[b])
                mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        dataread_d   = dataread_q;
        address_d    = address_q;
        memtoreg_d   = memtoreg_q;
        regwrite_d   = regwrite_q;
        return_d     = return_q;
        halt_d       = halt_q;
        regdest_d    = regdest_q;
        retaddr_d    = retaddr_q;
        misaligned_d = misaligned_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == ADDR_BITS'(MEM_DEPTH - 1))
                state_d = ST_RUN;
        end else if (i_enable) begin
            // Read is taken before the edge, so a same-cycle store returns pre-write data
            dataread_d   = (i_memread && !misaligned)
                         ? load_extend(mem[word_idx], lane, i_size, i_unsigned) : '0;
            address_d    = i_alu_result;
            memtoreg_d   = i_memtoreg;
            regwrite_d   = i_regwrite && !misaligned;
            return_d     = i_return;
            halt_d       = i_halt;
            regdest_d    = i_regdest;
            retaddr_d    = i_return_address;
            misaligned_d = misaligned;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            dataread_q   <= '0;
            address_q    <= '0;
            memtoreg_q   <= 1'b0;
            regwrite_q   <= 1'b0;
            return_q     <= 1'b0;
            halt_q       <= 1'b0;
            regdest_q    <= '0;
            retaddr_q    <= '0;
            misaligned_q <= 1'b0;
            debug_q      <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            dataread_q   <= dataread_d;
            address_q    <= address_d;
            memtoreg_q   <= memtoreg_d;
            regwrite_q   <= regwrite_d;
            return_q     <= return_d;
            halt_q       <= halt_d;
            regdest_q    <= regdest_d;
            retaddr_q    <= retaddr_d;
            misaligned_q <= misaligned_d;
            debug_q      <= mem[i_debug_addr];
        end
    end

    assign o_ready          = (state_q == ST_RUN);
    assign o_dataread       = dataread_q;
    assign o_address        = address_q;
    assign o_memtoreg       = memtoreg_q;
    assign o_regwrite       = regwrite_q;
    assign o_return         = return_q;
    assign o_halt           = halt_q;
    assign o_regdest        = regdest_q;
    assign o_return_address = retaddr_q;
    assign o_misaligned     = misaligned_q;
    assign o_debug_data     = debug_q;

endmodule
